// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register for the RV32 core.
// Registers operands and control. Computes the operand forwarding selects a
// cycle early so the EX-stage operand muxes are driven straight from flops.
// Detects load-use hazards, inserts bubbles and counts stall cycles.
module id_ex_fwd_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_reg_write_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [1:0]        ex_fwd_a_sel_o,
    output logic [1:0]        ex_fwd_b_sel_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;
    logic       rs1_hit;
    logic       rs2_hit;

    // Select for one source operand. The instruction currently in EX moves to
    // EX/MEM next cycle (01), EX/MEM moves to MEM/WB (10), and MEM/WB retires
    // now, so its value must come from the delayed write-back copy (11).
    // Checks run youngest first so the most recent producer wins.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              use_rs,
        input logic              ex_wr,
        input logic [REG_AW-1:0] ex_rd,
        input logic              em_wr,
        input logic [REG_AW-1:0] em_rd,
        input logic              mw_wr,
        input logic [REG_AW-1:0] mw_rd
    );
        if (!use_rs || rs == '0)          return 2'b00;
        else if (ex_wr && ex_rd == rs)    return 2'b01;
        else if (em_wr && em_rd == rs)    return 2'b10;
        else if (mw_wr && mw_rd == rs)    return 2'b11;
        else                              return 2'b00;
    endfunction

    // Load-use detection and next-cycle forwarding selects.
    always_comb begin
        rs1_hit   = id_use_rs1_i && (id_rs1_i == ex_rd_o);
        rs2_hit   = id_use_rs2_i && (id_rs2_i == ex_rd_o);
        stall_o   = !flush_i && id_valid_i && ex_valid_o && ex_mem_read_o &&
                    (ex_rd_o != '0) && (rs1_hit || rs2_hit);
        fwd_a_nxt = fwd_sel(id_rs1_i, id_use_rs1_i, ex_valid_o && ex_reg_write_o,
                            ex_rd_o, exmem_reg_write_i, exmem_rd_i,
                            memwb_reg_write_i, memwb_rd_i);
        fwd_b_nxt = fwd_sel(id_rs2_i, id_use_rs2_i, ex_valid_o && ex_reg_write_o,
                            ex_rd_o, exmem_reg_write_i, exmem_rd_i,
                            memwb_reg_write_i, memwb_rd_i);
    end

    // Pipeline register update: reset > hold > flush/stall bubble > load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o     <= 1'b0;
            ex_rs1_data_o  <= '0;
            ex_rs2_data_o  <= '0;
            ex_fwd_a_sel_o <= 2'b00;
            ex_fwd_b_sel_o <= 2'b00;
            ex_rd_o        <= '0;
            ex_reg_write_o <= 1'b0;
            ex_mem_read_o  <= 1'b0;
        end else if (hold_i) begin
            // everything keeps its value
        end else if (flush_i || stall_o) begin
            // Bubble: data and rd are left as-is since nothing consumes them.
            ex_valid_o     <= 1'b0;
            ex_reg_write_o <= 1'b0;
            ex_mem_read_o  <= 1'b0;
            ex_fwd_a_sel_o <= 2'b00;
            ex_fwd_b_sel_o <= 2'b00;
        end else begin
            ex_valid_o     <= id_valid_i;
            ex_rs1_data_o  <= id_rs1_data_i;
            ex_rs2_data_o  <= id_rs2_data_i;
            ex_fwd_a_sel_o <= fwd_a_nxt;
            ex_fwd_b_sel_o <= fwd_b_nxt;
            ex_rd_o        <= id_rd_i;
            ex_reg_write_o <= id_valid_i && id_reg_write_i;
            ex_mem_read_o  <= id_valid_i && id_mem_read_i;
        end
    end

    // Saturating count of load-use stall cycles, frozen during hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_count_o <= '0;
        end else if (!hold_i && stall_o && stall_count_o != '1) begin
            stall_count_o <= stall_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Self-checking bench for id_ex_fwd_stage: directed scenarios plus random
// traffic, all compared against a behavioural model of the EX slot.
module tb_id_ex_fwd_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 4;

    logic            clk_i = 1'b0;
    logic            rst_i, hold_i, flush_i, id_valid_i;
    logic [AW-1:0]   id_rs1_i, id_rs2_i, id_rd_i, exmem_rd_i, memwb_rd_i;
    logic            id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_mem_read_i;
    logic [XLEN-1:0] id_rs1_data_i, id_rs2_data_i;
    logic            exmem_reg_write_i, memwb_reg_write_i;
    logic            ex_valid_o, ex_reg_write_o, ex_mem_read_o, stall_o;
    logic [XLEN-1:0] ex_rs1_data_o, ex_rs2_data_o;
    logic [1:0]      ex_fwd_a_sel_o, ex_fwd_b_sel_o;
    logic [AW-1:0]   ex_rd_o;
    logic [CW-1:0]   stall_count_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model of what EX should hold.
    logic            m_valid, m_rw, m_mr, m_dc;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_d1, m_d2;
    logic [1:0]      m_sa, m_sb;
    int unsigned     m_cnt;
    logic            m_stall;

    id_ex_fwd_stage #(.XLEN(XLEN), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .exmem_rd_i(exmem_rd_i),
        .exmem_reg_write_i(exmem_reg_write_i), .memwb_rd_i(memwb_rd_i),
        .memwb_reg_write_i(memwb_reg_write_i), .ex_valid_o(ex_valid_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_fwd_a_sel_o(ex_fwd_a_sel_o), .ex_fwd_b_sel_o(ex_fwd_b_sel_o),
        .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .stall_o(stall_o),
        .stall_count_o(stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Producers listed youngest first: 1 = in EX now, 2 = EX/MEM, 3 = MEM/WB.
    function automatic logic [1:0] ref_sel(input logic [AW-1:0] rs, input logic use_rs);
        logic [AW-1:0] prd [0:2];
        logic          pw  [0:2];
        prd[0] = m_rd;       pw[0] = m_valid & m_rw;
        prd[1] = exmem_rd_i; pw[1] = exmem_reg_write_i;
        prd[2] = memwb_rd_i; pw[2] = memwb_reg_write_i;
        if (!use_rs || rs == 0) return 2'd0;
        for (int i = 0; i < 3; i++)
            if (pw[i] && prd[i] == rs) return 2'(i + 1);
        return 2'd0;
    endfunction

    function automatic logic ref_stall();
        logic dep;
        dep = (id_use_rs1_i && id_rs1_i == m_rd) || (id_use_rs2_i && id_rs2_i == m_rd);
        return !flush_i && id_valid_i && m_valid && m_mr && m_rd != 0 && dep;
    endfunction

    task automatic model_update();
        logic [1:0] sa, sb;
        sa = ref_sel(id_rs1_i, id_use_rs1_i);
        sb = ref_sel(id_rs2_i, id_use_rs2_i);
        if (rst_i) begin
            {m_valid, m_rw, m_mr, m_dc} = '0;
            m_rd = '0; m_d1 = '0; m_d2 = '0; m_sa = '0; m_sb = '0; m_cnt = 0;
        end else if (hold_i) begin
        end else if (flush_i || m_stall) begin
            {m_valid, m_rw, m_mr} = '0;
            m_sa = '0; m_sb = '0; m_dc = 1'b1;
            if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
            m_valid = id_valid_i;
            m_rw = id_valid_i & id_reg_write_i;
            m_mr = id_valid_i & id_mem_read_i;
            m_rd = id_rd_i; m_d1 = id_rs1_data_i; m_d2 = id_rs2_data_i;
            m_sa = sa; m_sb = sb; m_dc = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("ex_valid", XLEN'(ex_valid_o), XLEN'(m_valid));
        check("ex_reg_write", XLEN'(ex_reg_write_o), XLEN'(m_rw));
        check("ex_mem_read", XLEN'(ex_mem_read_o), XLEN'(m_mr));
        check("fwd_a_sel", XLEN'(ex_fwd_a_sel_o), XLEN'(m_sa));
        check("fwd_b_sel", XLEN'(ex_fwd_b_sel_o), XLEN'(m_sb));
        check("stall_count", XLEN'(stall_count_o), XLEN'(m_cnt));
        if (!m_dc) begin
            check("ex_rd", XLEN'(ex_rd_o), XLEN'(m_rd));
            check("ex_rs1_data", ex_rs1_data_o, m_d1);
            check("ex_rs2_data", ex_rs2_data_o, m_d2);
        end
    endtask

    // One clock: apply control, check stall, advance model, check EX outputs.
    task automatic step(input logic rs, input logic hd, input logic fl);
        rst_i = rs; hold_i = hd; flush_i = fl;
        #1;
        m_stall = ref_stall();
        check("stall", XLEN'(stall_o), XLEN'(m_stall));
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic drive_id(input logic v, input logic [AW-1:0] rs1, input logic u1,
                            input logic [AW-1:0] rs2, input logic u2,
                            input logic [AW-1:0] rd, input logic rw, input logic mr);
        id_valid_i = v; id_rs1_i = rs1; id_use_rs1_i = u1;
        id_rs2_i = rs2; id_use_rs2_i = u2; id_rd_i = rd;
        id_reg_write_i = rw; id_mem_read_i = mr;
        id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
    endtask

    task automatic drive_fwd(input logic [AW-1:0] emrd, input logic emw,
                             input logic [AW-1:0] mwrd, input logic mww);
        exmem_rd_i = emrd; exmem_reg_write_i = emw;
        memwb_rd_i = mwrd; memwb_reg_write_i = mww;
    endtask

    // lw x7 followed by a dependent add: yields exactly one stall cycle.
    task automatic one_load_use();
        drive_fwd(0, 0, 0, 0);
        drive_id(1, 1, 1, 0, 0, 7, 1, 1); step(0, 0, 0);
        drive_id(1, 7, 1, 7, 1, 8, 1, 0); step(0, 0, 0);
    endtask

    initial begin
        {m_valid, m_rw, m_mr, m_dc, m_stall} = '0;
        m_rd = '0; m_d1 = '0; m_d2 = '0; m_sa = '0; m_sb = '0; m_cnt = 0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        drive_fwd(0, 0, 0, 0);
        rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        step(1, 0, 0);
        check("reset_valid", XLEN'(ex_valid_o), 0);

        // Distance 1..4 from add x5 to sub x6,x5,x1.
        drive_id(1, 1, 1, 2, 1, 5, 1, 0); step(0, 0, 0);
        drive_id(1, 5, 1, 1, 1, 6, 1, 0); step(0, 0, 0);
        check("dist1_a", XLEN'(ex_fwd_a_sel_o), 1);
        check("dist1_b", XLEN'(ex_fwd_b_sel_o), 0);
        for (int d = 2; d <= 4; d++) begin
            drive_fwd(0, 0, 0, 0);
            drive_id(1, 9, 1, 9, 1, 9, 0, 0); step(0, 0, 0);
            drive_fwd(5, d == 2, 5, d == 3);
            drive_id(1, 5, 1, 1, 1, 6, 1, 0); step(0, 0, 0);
            check("distN_a", XLEN'(ex_fwd_a_sel_o), (d == 4) ? 0 : d);
        end

        // x0 producer/consumer and an unused operand matching a load.
        drive_fwd(0, 1, 0, 1);
        drive_id(1, 1, 1, 1, 1, 0, 1, 0); step(0, 0, 0);
        drive_id(1, 0, 1, 0, 1, 3, 1, 0); step(0, 0, 0);
        check("x0_a", XLEN'(ex_fwd_a_sel_o), 0);
        drive_fwd(0, 0, 0, 0);
        drive_id(1, 1, 1, 0, 0, 4, 1, 1); step(0, 0, 0);
        drive_id(1, 4, 0, 4, 0, 4, 1, 0); step(0, 0, 0);
        check("lui_a", XLEN'(ex_fwd_a_sel_o), 0);

        // Load-use: stall, bubble, then both selects from MEM/WB path.
        step(1, 0, 0);
        one_load_use();
        check("lu_bubble", XLEN'(ex_valid_o), 0);
        drive_fwd(7, 1, 0, 0); step(0, 0, 0);
        check("lu_a", XLEN'(ex_fwd_a_sel_o), 2);
        check("lu_b", XLEN'(ex_fwd_b_sel_o), 2);
        check("lu_cnt", XLEN'(stall_count_o), 1);

        // Hold over a pending stall, then release.
        drive_fwd(0, 0, 0, 0);
        drive_id(1, 1, 1, 0, 0, 7, 1, 1); step(0, 0, 0);
        drive_id(1, 7, 1, 0, 0, 8, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        check("hold_cnt", XLEN'(stall_count_o), 1);
        step(0, 0, 0);
        check("hold_rel_cnt", XLEN'(stall_count_o), 2);

        // Flush coincident with a load-use match.
        drive_id(1, 1, 1, 0, 0, 7, 1, 1); step(0, 0, 0);
        drive_id(1, 7, 1, 0, 0, 8, 1, 0); step(0, 0, 1);
        check("flush_cnt", XLEN'(stall_count_o), 2);

        // Reset mid-operation with a count of 5.
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) one_load_use();
        drive_id(1, 1, 1, 2, 1, 3, 1, 0); step(0, 0, 0);
        check("pre_rst_cnt", XLEN'(stall_count_o), 5);
        step(1, 0, 0);
        check("rst_cnt", XLEN'(stall_count_o), 0);
        check("rst_valid", XLEN'(ex_valid_o), 0);

        // Saturation of the counter.
        for (int i = 0; i < 17; i++) one_load_use();
        check("sat_cnt", XLEN'(stall_count_o), (1 << CW) - 1);

        // Random traffic on a small register set to force frequent hazards.
        for (int i = 0; i < 600; i++) begin
            drive_fwd(AW'($urandom_range(0, 3)), 1'($urandom),
                      AW'($urandom_range(0, 3)), 1'($urandom));
            drive_id(($urandom_range(0, 9) != 0), AW'($urandom_range(0, 3)),
                     1'($urandom), AW'($urandom_range(0, 3)), 1'($urandom),
                     AW'($urandom_range(0, 3)), 1'($urandom),
                     ($urandom_range(0, 2) == 0));
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the RV32 core. Registers operand data and control.
- Computes the 2-bit forwarding selects one cycle early, so each select reaches the EX-stage 4-input operand muxes straight from a flop.
- Detects load-use hazards, inserts bubbles, and counts stall cycles.

Parameters:
- XLEN, 32, operand data width
- REG_AW, 5, register address width
- CNT_W, 32, stall counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset: synchronous, active-high
- hold_i  in  1  global pipeline freeze (memory wait)
- flush_i  in  1  branch/jump flush of the instruction in ID
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_i, id_rs2_i  in  REG_AW  source register addresses
- id_use_rs1_i, id_use_rs2_i  in  1  instruction actually reads rs1 / rs2
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register file read data
- id_rd_i  in  REG_AW  destination register
- id_reg_write_i, id_mem_read_i  in  1  instruction writes rd / is a load
- exmem_rd_i  in  REG_AW  rd currently in EX/MEM
- exmem_reg_write_i  in  1  EX/MEM writes rd
- memwb_rd_i  in  REG_AW  rd currently in MEM/WB
- memwb_reg_write_i  in  1  MEM/WB writes rd
- ex_valid_o  out  1  EX holds a valid instruction
- ex_rs1_data_o, ex_rs2_data_o  out  XLEN  registered operands (mux input 00)
- ex_fwd_a_sel_o, ex_fwd_b_sel_o  out  2  operand selects: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 delayed WB value
- ex_rd_o  out  REG_AW  registered rd
- ex_reg_write_o, ex_mem_read_o  out  1  registered control
- stall_o  out  1  combinational load-use stall to PC/IF/ID
- stall_count_o  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_i high at clock edge):
  - All outputs 0, including selects 00 and stall_count_o.
  - stall_o is 0 during reset because ex_valid_o is 0.
- Load-use hazard:
  - stall_o = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & ((id_use_rs1_i & id_rs1_i == ex_rd_o) | (id_use_rs2_i & id_rs2_i == ex_rd_o)).
  - stall_o is forced 0 while flush_i is high.
- Update priority at each edge: rst_i > hold_i > flush_i > stall_o > normal load.
- hold_i: every register, including stall_count_o, keeps its value. flush_i is ignored while hold_i is high; the controller keeps flush_i asserted until hold_i drops.
- flush_i or stall_o inserts a bubble:
  - ex_valid_o, ex_reg_write_o, ex_mem_read_o and both selects go to 0.
  - Data, rd and other fields may take any value.
- Normal load:
  - ex_valid_o <= id_valid_i.
  - Control is gated by id_valid_i (invalid ID never writes or loads).
  - Data, rd and selects load from ID.
- Select computation for operand X, evaluated from current state and applied in the next cycle's EX:
  - rsX == 0 or !id_use_rsX -> 00
  - else ex_valid_o & ex_reg_write_o & ex_rd_o == rsX -> 01 (producer will be in EX/MEM)
  - else exmem_reg_write_i & exmem_rd_i == rsX -> 10 (producer will be in MEM/WB)
  - else memwb_reg_write_i & memwb_rd_i == rsX -> 11 (producer retires this cycle; regfile has no write-through)
  - else 00
  - Youngest producer wins.
- After a stall bubble, the held instruction recomputes its selects. The load is then in EX/MEM, so the result is 10; a second stall cannot occur.
- stall_count_o increments on every non-hold cycle with stall_o = 1 and saturates at all-ones.
- Latency: one cycle ID->EX. There are no combinational paths from ID inputs to ex_* outputs.

Test Plan:
- Reset mid-operation: ex_valid_o = 1, stall_count_o = 5, assert rst_i for 1 cycle -> next edge every output is 0.
- Back-to-back ALU dependency: add x5 then sub x6,x5,x1 -> sub in EX has ex_fwd_a_sel_o = 01, ex_fwd_b_sel_o = 00. With one unrelated instruction between: sel 10. With two between: sel 11. With three between: sel 00.
- Load-use: lw x7 then add x8,x7,x7 -> stall_o = 1 for exactly 1 cycle, bubble in EX (ex_valid_o = 0), then add enters EX with both selects 10, and stall_count_o = 1.
- x0 and unused operand: producer writes x0, consumer reads x0 -> sel 00. lui with id_use_rs1_i = 0 matching ex_rd_o -> sel 00, no stall.
- hold_i during a pending load-use stall for 3 cycles -> ex_* outputs frozen, stall_count_o unchanged. After release, exactly 1 stall cycle is counted.
- flush_i coincident with a load-use match -> stall_o = 0, bubble inserted, stall_count_o unchanged. Counter preset to all-ones plus a stall -> stays all-ones.
